// File: rtl/uno_card_pile.sv
// uno_card_pile: UNO draw/discard pile manager with Fisher-Yates
// shuffle and automatic discard recycling.
// Ports: i_clk, i_rst (sync, active-high); i_start/i_seed reload and
// shuffle; draw side i_draw_req/i_draw_n, o_card_valid/o_card/
// i_card_ready; discard side i_disc_valid/i_disc_card/o_disc_ready;
// status o_ready, o_draw_cnt, o_disc_cnt, o_short, o_overflow.
module uno_card_pile #(
  parameter int COPIES   = 1,
  parameter int CARD_W   = 6,
  parameter int MAX_DRAW = 4,
  localparam int DEPTH   = 108 * COPIES,
  localparam int AW      = $clog2(DEPTH),
  localparam int NW      = $clog2(MAX_DRAW + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [15:0]       i_seed,
  input  logic              i_draw_req,
  input  logic [NW-1:0]     i_draw_n,
  output logic              o_card_valid,
  output logic [CARD_W-1:0] o_card,
  input  logic              i_card_ready,
  input  logic              i_disc_valid,
  input  logic [CARD_W-1:0] i_disc_card,
  output logic              o_disc_ready,
  output logic              o_ready,
  output logic [AW:0]       o_draw_cnt,
  output logic [AW:0]       o_disc_cnt,
  output logic              o_short,
  output logic              o_overflow
);

  typedef enum logic [2:0] {
    IDLE, INIT, SHUFFLE, READY, DRAW, RECYCLE
  } state_t;

  localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT1  = (AW+1)'(1);
  localparam logic [AW+1:0] FILLM = (AW+2)'(DEPTH);

  state_t            state_q, state_d;
  logic [CARD_W-1:0] mem_q [DEPTH];
  logic [CARD_W-1:0] mem_d [DEPTH];
  logic [AW:0]       draw_cnt_q, draw_cnt_d;
  logic [AW:0]       disc_cnt_q, disc_cnt_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [NW-1:0]     rem_q, rem_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic              pend_q, pend_d;

  logic [AW-1:0]     cand, top, disc_wr;
  logic [AW+1:0]     fill;
  logic              fb, go;

  // Entry i of the fresh deck: 27 cards per color block.
  function automatic logic [CARD_W-1:0] init_card(input int i);
    int k, c;
    logic [3:0] v;
    k = i % 27;
    c = (i / 27) % 4;
    if (k == 0)       v = 4'd0;
    else if (k <= 24) v = 4'((k + 1) >> 1);
    else if (k == 25) v = 4'd13;
    else              v = 4'd14;
    return CARD_W'({2'(c), v});
  endfunction

  // Smallest all-ones mask covering x (next pow2 >= x+1, minus 1).
  function automatic logic [AW-1:0] smear(input logic [AW-1:0] x);
    logic [AW-1:0] m;
    m = x;
    for (int s = 1; s < AW; s = s * 2) m = m | (m >> s);
    return m;
  endfunction

  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    draw_cnt_d = draw_cnt_q;
    disc_cnt_d = disc_cnt_q;
    idx_d      = idx_q;
    rem_d      = rem_q;
    lfsr_d     = lfsr_q;
    pend_d     = pend_q;

    o_card_valid = 1'b0;
    o_card       = '0;
    o_disc_ready = 1'b0;
    o_short      = 1'b0;
    o_overflow   = 1'b0;

    fb      = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    cand    = lfsr_q[AW-1:0] & smear(idx_q);
    top     = draw_cnt_q[AW-1:0] - AW'(1);
    disc_wr = AW'(DEPTH - 1) - disc_cnt_q[AW-1:0];
    fill    = {1'b0, draw_cnt_q} + {1'b0, disc_cnt_q};
    go      = i_start && (state_q == IDLE ||
                          state_q == READY ||
                          state_q == DRAW);

    unique case (state_q)
      IDLE: ;
      INIT: begin
        for (int i = 0; i < DEPTH; i++) mem_d[i] = init_card(i);
        draw_cnt_d = FULL;
        disc_cnt_d = '0;
        idx_d      = AW'(DEPTH - 1);
        pend_d     = 1'b0;
        state_d    = SHUFFLE;
      end
      SHUFFLE: begin
        lfsr_d = {lfsr_q[14:0], fb};
        if (idx_q == '0) begin
          state_d = pend_q ? DRAW : READY;
          pend_d  = 1'b0;
        end else if (cand <= idx_q) begin
          mem_d[idx_q] = mem_q[cand];
          mem_d[cand]  = mem_q[idx_q];
          idx_d        = idx_q - AW'(1);
          if (idx_q == AW'(1)) begin
            state_d = pend_q ? DRAW : READY;
            pend_d  = 1'b0;
          end
        end
      end
      READY: begin
        o_disc_ready = 1'b1;
        if (i_disc_valid) begin
          if (fill == FILLM) begin
            o_overflow = 1'b1;
          end else begin
            mem_d[disc_wr] = i_disc_card;
            disc_cnt_d     = disc_cnt_q + CNT1;
          end
        end
        if (i_draw_req && i_draw_n != '0) begin
          rem_d   = i_draw_n;
          state_d = DRAW;
        end
      end
      DRAW: begin
        if (draw_cnt_q != '0) begin
          o_card_valid = 1'b1;
          o_card       = mem_q[top];
          if (i_card_ready) begin
            draw_cnt_d = draw_cnt_q - CNT1;
            rem_d      = rem_q - NW'(1);
            if (rem_q == NW'(1)) state_d = READY;
          end
        end else if (disc_cnt_q >= (AW+1)'(2)) begin
          state_d = RECYCLE;
          pend_d  = 1'b1;
        end else begin
          o_short = 1'b1;
          state_d = READY;
        end
      end
      RECYCLE: begin
        // Slide the discard pile toward the end so its top card
        // stays put while the bottom card moves to the draw pile.
        for (int i = 1; i < DEPTH; i++)
          if (i + int'(disc_cnt_q) > DEPTH) mem_d[i] = mem_q[i-1];
        mem_d[draw_cnt_q[AW-1:0]] = mem_q[DEPTH-1];
        draw_cnt_d = draw_cnt_q + CNT1;
        disc_cnt_d = disc_cnt_q - CNT1;
        if (disc_cnt_q == (AW+1)'(2)) begin
          state_d = SHUFFLE;
          idx_d   = draw_cnt_q[AW-1:0];
        end
      end
      default: state_d = IDLE;
    endcase

    if (go) begin
      state_d = INIT;
      lfsr_d  = (i_seed == 16'h0) ? 16'h0001 : i_seed;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      draw_cnt_q <= '0;
      disc_cnt_q <= '0;
      idx_q      <= '0;
      rem_q      <= '0;
      lfsr_q     <= 16'h0001;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      draw_cnt_q <= draw_cnt_d;
      disc_cnt_q <= disc_cnt_d;
      idx_q      <= idx_d;
      rem_q      <= rem_d;
      lfsr_q     <= lfsr_d;
      pend_q     <= pend_d;
    end
  end

  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  assign o_ready    = (state_q == READY);
  assign o_draw_cnt = draw_cnt_q;
  assign o_disc_cnt = disc_cnt_q;

endmodule

// File: tb/tb_uno_card_pile.sv
// tb_uno_card_pile: directed bench for uno_card_pile.
// Shuffle, stalled draws, recycle, short, overflow and reset.
module tb_uno_card_pile;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, draw_req, card_valid, card_ready;
  logic        disc_valid, disc_ready, rdy, short_p, ovf;
  logic [15:0] seed;
  logic [2:0]  n_sig;
  logic [5:0]  card, disc_card, held;
  logic [7:0]  draw_cnt, disc_cnt;

  int errors = 0;
  int checks = 0;
  int shorts, ready_cycles, bad, vbad;
  int cnt [64];
  logic [5:0] got [$];
  logic [5:0] acc [$];
  logic [5:0] order1 [$];
  logic [5:0] order2 [$];
  logic [5:0] rc [$];
  logic [5:0] dv [5];
  logic       last_ovf, last_drdy;
  logic [4:0] pat;

  uno_card_pile dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_seed       (seed),
    .i_draw_req   (draw_req),
    .i_draw_n     (n_sig),
    .o_card_valid (card_valid),
    .o_card       (card),
    .i_card_ready (card_ready),
    .i_disc_valid (disc_valid),
    .i_disc_card  (disc_card),
    .o_disc_ready (disc_ready),
    .o_ready      (rdy),
    .o_draw_cnt   (draw_cnt),
    .o_disc_cnt   (disc_cnt),
    .o_short      (short_p),
    .o_overflow   (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expire(input string tag);
    checks++;
    errors++;
    $display("FAIL %s: observed timeout expected event", tag);
  endtask

  function automatic logic [5:0] g(input int i);
    if (i < got.size()) return got[i];
    return 6'h3F;
  endfunction

  task automatic do_start(input logic [15:0] s);
    int c;
    @(negedge clk);
    start = 1'b1;
    seed  = s;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    #1;
    while (!rdy && c < 5000) begin
      @(negedge clk);
      #1;
      c++;
    end
    if (!rdy) expire("start_tmo");
    ready_cycles = c;
  endtask

  task automatic pull(input int n);
    int c;
    c = 0;
    got.delete();
    shorts = 0;
    while (got.size() < n && c < 400) begin
      card_ready = 1'b1;
      #1;
      if (short_p) begin
        shorts++;
        @(negedge clk);
        break;
      end
      if (card_valid) got.push_back(card);
      @(negedge clk);
      c++;
    end
    card_ready = 1'b0;
    if (got.size() < n && shorts == 0) expire("pull_tmo");
  endtask

  task automatic draw(input int n);
    @(negedge clk);
    draw_req = 1'b1;
    n_sig    = 3'(n);
    @(negedge clk);
    draw_req = 1'b0;
    n_sig    = '0;
    pull(n);
  endtask

  task automatic discard(input logic [5:0] d);
    @(negedge clk);
    disc_valid = 1'b1;
    disc_card  = d;
    #1;
    last_ovf  = ovf;
    last_drdy = disc_ready;
    @(negedge clk);
    disc_valid = 1'b0;
  endtask

  task automatic drain();
    acc.delete();
    for (int r = 0; r < 27; r++) begin
      draw(4);
      foreach (got[i]) acc.push_back(got[i]);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; seed = '0;
    draw_req = 1'b0; n_sig = '0; card_ready = 1'b0;
    disc_valid = 1'b0; disc_card = '0;
    dv[0] = 6'h05; dv[1] = 6'h1A; dv[2] = 6'h2C;
    dv[3] = 6'h3D; dv[4] = 6'h0E;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", rdy, 0);
    chk("rst_draw_cnt", draw_cnt, 0);
    chk("rst_disc_cnt", disc_cnt, 0);
    chk("rst_valid", card_valid, 0);
    chk("rst_disc_ready", disc_ready, 0);
    chk("rst_pulses", {short_p, ovf}, 0);
    rst = 1'b0;

    @(negedge clk);
    draw_req = 1'b1;
    n_sig    = 3'd2;
    @(negedge clk);
    draw_req = 1'b0;
    n_sig    = '0;
    #1;
    chk("idle_valid", card_valid, 0);
    chk("idle_ready", rdy, 0);

    do_start(16'hACE1);
    chk("shuf_len", ready_cycles >= 107, 1);
    chk("init_draw_cnt", draw_cnt, 108);
    chk("init_disc_cnt", disc_cnt, 0);
    drain();
    order1 = acc;
    chk("drain_size", order1.size(), 108);
    foreach (cnt[i]) cnt[i] = 0;
    foreach (order1[i]) cnt[order1[i]]++;
    bad = 0;
    for (int c = 0; c < 64; c++) begin
      int v, e;
      v = c % 16;
      e = (v == 0 || v == 13 || v == 14) ? 1 : (v <= 12 ? 2 : 0);
      if (cnt[c] != e) bad++;
    end
    chk("multiset", bad, 0);
    #1;
    chk("empty_draw_cnt", draw_cnt, 0);

    do_start(16'hACE1);
    drain();
    order2 = acc;
    bad = 0;
    for (int i = 0; i < 108; i++)
      if (i >= order2.size() || order2[i] !== order1[i]) bad++;
    chk("rerun_order", bad, 0);

    do_start(16'hACE1);
    @(negedge clk);
    draw_req = 1'b1;
    n_sig    = 3'd4;
    @(negedge clk);
    draw_req = 1'b0;
    n_sig    = '0;
    pat  = 5'b11101;
    vbad = 0;
    got.delete();
    for (int k = 0; k < 5; k++) begin
      card_ready = pat[k];
      #1;
      if (!card_valid) vbad++;
      if (k == 1) held = card;
      if (k == 2) chk("stall_hold", card, held);
      if (card_valid && card_ready) got.push_back(card);
      @(negedge clk);
    end
    card_ready = 1'b0;
    #1;
    chk("stall_valid_all", vbad, 0);
    chk("stall_taken", got.size(), 4);
    chk("stall_valid_off", card_valid, 0);
    chk("stall_ready", rdy, 1);
    chk("stall_cnt", draw_cnt, 104);
    bad = 0;
    for (int i = 0; i < 4; i++) if (g(i) !== order1[i]) bad++;
    chk("stall_cards", bad, 0);

    @(negedge clk);
    disc_valid = 1'b1;
    disc_card  = 6'h2B;
    draw_req   = 1'b1;
    n_sig      = 3'd1;
    #1;
    chk("sim_disc_ready", disc_ready, 1);
    chk("sim_no_ovf", ovf, 0);
    @(negedge clk);
    disc_valid = 1'b0;
    draw_req   = 1'b0;
    n_sig      = '0;
    pull(1);
    chk("sim_card", g(0), order1[4]);
    #1;
    chk("sim_disc_cnt", disc_cnt, 1);
    chk("sim_draw_cnt", draw_cnt, 103);

    do_start(16'hACE1);
    for (int r = 0; r < 26; r++) draw(4);
    draw(3);
    chk("pre_card", g(2), order1[106]);
    #1;
    chk("pre_draw_cnt", draw_cnt, 1);
    for (int i = 0; i < 5; i++) discard(dv[i]);
    #1;
    chk("disc5_cnt", disc_cnt, 5);
    chk("disc5_ovf", last_ovf, 0);
    chk("disc5_ready", last_drdy, 1);
    draw(3);
    chk("rc_n", got.size(), 3);
    chk("rc_short", shorts, 0);
    chk("rc_first", g(0), order1[107]);
    rc.delete();
    rc.push_back(g(1));
    rc.push_back(g(2));
    #1;
    chk("rc_draw_cnt", draw_cnt, 2);
    chk("rc_disc_cnt", disc_cnt, 1);
    draw(2);
    rc.push_back(g(0));
    rc.push_back(g(1));
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      int occ;
      occ = 0;
      foreach (rc[j]) if (rc[j] === dv[i]) occ++;
      if (occ != 1) bad++;
    end
    chk("rc_perm", bad, 0);
    #1;
    chk("rc2_draw_cnt", draw_cnt, 0);
    discard(6'h31);
    draw(1);
    chk("rc_top", g(0), dv[4]);
    #1;
    chk("rc_top_disc", disc_cnt, 1);
    draw(2);
    chk("short_once", shorts, 1);
    chk("short_nocard", got.size(), 0);
    #1;
    chk("short_ready", rdy, 1);
    chk("short_off", short_p, 0);

    do_start(16'h1234);
    discard(6'h07);
    chk("ovf_pulse", last_ovf, 1);
    #1;
    chk("ovf_draw_cnt", draw_cnt, 108);
    chk("ovf_disc_cnt", disc_cnt, 0);
    chk("ovf_off", ovf, 0);

    @(negedge clk);
    start = 1'b1;
    seed  = 16'h5A5A;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk("mid_shuf_cnt", draw_cnt, 108);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_shuf_cnt", draw_cnt, 0);
    chk("rst_shuf_ready", rdy, 0);
    rst = 1'b0;
    @(negedge clk);
    draw_req = 1'b1;
    n_sig    = 3'd1;
    @(negedge clk);
    draw_req = 1'b0;
    n_sig    = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("post_rst_valid", card_valid, 0);
    chk("post_rst_ready", rdy, 0);

    do_start(16'hBEEF);
    @(negedge clk);
    draw_req   = 1'b1;
    n_sig      = 3'd4;
    card_ready = 1'b0;
    @(negedge clk);
    draw_req = 1'b0;
    n_sig    = '0;
    #1;
    chk("mid_draw_valid", card_valid, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_draw_valid", card_valid, 0);
    chk("rst_draw_cnt", draw_cnt, 0);
    chk("rst_draw_rdy", {rdy, disc_ready}, 0);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
